logic_unit_arbiter: RTL

Round-robin arbiter that shares a single WIDTH-bit configurable logic unit (AND / OR / XOR / AND-NOT) between two requesters of the RISC-V core datapath. Each requester presents operands and an opcode through a valid/ready handshake. The arbiter grants one request at a time, registers the logic result, and returns it tagged with the requester ID through a valid/ready response port.

---
 rtl/logic_arb_pkg.sv | 19 +
 rtl/logic_unit_arbiter_logic_unit.sv | 25 ++
 rtl/logic_unit_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/logic_arb_pkg.sv
// Shared types for the logic-unit arbiter.
// Optional grant counters: LOGIC_ARB_STATS_EN.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ANDN
  } logic_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational WIDTH-bit logic unit.
// Computes AND / OR / XOR / AND-NOT of two operands.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic_op_t        op_i,
  output logic [WIDTH-1:0] s_o
);

  always_comb begin
    s_o = '0;
    unique case (op_i)
      OP_AND:  s_o = a_i & b_i;
      OP_OR:   s_o = a_i | b_i;
      OP_XOR:  s_o = a_i ^ b_i;
      OP_ANDN: s_o = a_i & ~b_i;
      default: s_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter around one logic unit.
// Optional grant counters: LOGIC_ARB_STATS_EN.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [1:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [1:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0_o,
  output logic [STAT_W-1:0] grant_cnt1_o
`endif
);

  arb_state_t       state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             idle;
  logic             gnt0, gnt1;
  logic             accept;
  logic             win_id;
  logic_op_t        win_op;
  logic [WIDTH-1:0] win_a, win_b;
  logic [WIDTH-1:0] lu_res;

  // Ready is masked while reset is held so nothing looks accepted.
  assign idle = (state_q == ST_IDLE) && rstn_i;

  assign gnt0 = req0_valid_i && (!req1_valid_i || !prio_q);
  assign gnt1 = req1_valid_i && (!req0_valid_i || prio_q);

  assign req0_ready_o = idle && gnt0;
  assign req1_ready_o = idle && gnt1;
  assign accept       = req0_ready_o || req1_ready_o;
  assign win_id       = gnt1;

  assign win_op = win_id ? logic_op_t'(req1_op_i) : logic_op_t'(req0_op_i);
  assign win_a  = win_id ? req1_a_i : req0_a_i;
  assign win_b  = win_id ? req1_b_i : req0_b_i;

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_lu (
    .a_i (win_a),
    .b_i (win_b),
    .op_i(win_op),
    .s_o (lu_res)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESP;
          prio_d  = !win_id;
          id_d    = win_id;
          data_d  = lu_res;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;

`ifdef LOGIC_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt0_q, grant_cnt1_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (req0_ready_o) grant_cnt0_q <= grant_cnt0_q + 1'b1;
      if (req1_ready_o) grant_cnt1_q <= grant_cnt1_q + 1'b1;
    end
  end

  assign grant_cnt0_o = grant_cnt0_q;
  assign grant_cnt1_o = grant_cnt1_q;
`endif

endmodule
